// File: rtl/inst_predecode_queue.sv
// Instruction queue between fetch and decode. Each word is classified
// as it is enqueued. A branch or jump at the head is held back until its
// delay slot is also queued, so the pair reaches decode back to back.
module inst_predecode_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             in_fault,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [PC_W-1:0]  out_pc,
  output logic [3:0]       out_class,
  output logic             out_fault,
  output logic             out_is_bds,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_LOAD    = 4'd1,
    CLS_STORE   = 4'd2,
    CLS_BRANCH  = 4'd3,
    CLS_JUMP    = 4'd4,
    CLS_MULDIV  = 4'd5,
    CLS_CP0     = 4'd6,
    CLS_TRAP    = 4'd7,
    CLS_SYSCALL = 4'd8,
    CLS_BREAK   = 4'd9,
    CLS_CACHE   = 4'd10,
    CLS_RI      = 4'd15
  } iclass_e;

  logic [31:0]     inst_mem  [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [3:0]      class_mem [DEPTH];
  logic            fault_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             bds_flag;
  iclass_e          in_class;
  logic [5:0]       op, func;
  logic [4:0]       rt;
  logic             enq, deq, head_ctrl, head_fault, not_empty;

  // Classify the incoming word from its opcode, function and rt fields
  always_comb begin
    op       = in_inst[31:26];
    func     = in_inst[5:0];
    rt       = in_inst[20:16];
    in_class = CLS_RI;
    unique case (op)
      6'b000000: begin
        case (func)
          6'b001000, 6'b001001:                         in_class = CLS_JUMP;
          6'b001100:                                    in_class = CLS_SYSCALL;
          6'b001101:                                    in_class = CLS_BREAK;
          6'b010000, 6'b010001, 6'b010010, 6'b010011,
          6'b011000, 6'b011001, 6'b011010, 6'b011011:   in_class = CLS_MULDIV;
          6'b110000, 6'b110001, 6'b110010, 6'b110011,
          6'b110100, 6'b110110:                         in_class = CLS_TRAP;
          6'b000000, 6'b000001, 6'b000010, 6'b000011,
          6'b000100, 6'b000110, 6'b000111, 6'b001010,
          6'b001011, 6'b001111, 6'b100000, 6'b100001,
          6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011:   in_class = CLS_ALU;
          default:                                      in_class = CLS_RI;
        endcase
      end
      6'b000001: begin
        case (rt)
          5'b00000, 5'b00001, 5'b10000, 5'b10001:       in_class = CLS_BRANCH;
          5'b01000, 5'b01001, 5'b01010, 5'b01011,
          5'b01100, 5'b01110:                           in_class = CLS_TRAP;
          default:                                      in_class = CLS_RI;
        endcase
      end
      6'b011100: begin
        case (func)
          6'b000000, 6'b000001, 6'b000010,
          6'b000100, 6'b000101:                         in_class = CLS_MULDIV;
          6'b100000, 6'b100001:                         in_class = CLS_ALU;
          default:                                      in_class = CLS_RI;
        endcase
      end
      6'b000010, 6'b000011:                             in_class = CLS_JUMP;
      6'b000100, 6'b000101, 6'b000110, 6'b000111:       in_class = CLS_BRANCH;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111:       in_class = CLS_ALU;
      6'b010000:                                        in_class = CLS_CP0;
      6'b010001, 6'b010010, 6'b010011:                  in_class = CLS_ALU;
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110:                  in_class = CLS_LOAD;
      6'b101000, 6'b101001, 6'b101010, 6'b101011,
      6'b101110:                                        in_class = CLS_STORE;
      6'b101111:                                        in_class = CLS_CACHE;
      default:                                          in_class = CLS_RI;
    endcase
  end

  // Handshakes and head presentation; data is forced to zero when nothing is held
  always_comb begin
    not_empty  = (count != '0) && !rst;
    head_fault = fault_mem[rd_ptr];
    head_ctrl  = (class_mem[rd_ptr] == CLS_BRANCH) || (class_mem[rd_ptr] == CLS_JUMP);
    in_ready   = !rst && (count != CNT_W'(DEPTH));
    out_valid  = not_empty && (!head_ctrl || head_fault || (count >= CNT_W'(2)));
    enq        = in_valid && in_ready && !flush;
    deq        = out_valid && out_ready;
    out_is_bds = bds_flag && out_valid;
    out_inst   = not_empty ? inst_mem[rd_ptr]  : '0;
    out_pc     = not_empty ? pc_mem[rd_ptr]    : '0;
    out_class  = not_empty ? class_mem[rd_ptr] : '0;
    out_fault  = not_empty && head_fault;
  end

  // Entry storage, written on accepted enqueue only
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr]  <= in_inst;
      pc_mem[wr_ptr]    <= in_pc;
      class_mem[wr_ptr] <= in_class;
      fault_mem[wr_ptr] <= in_fault;
    end
  end

  // Pointers, occupancy and delay-slot tracking; reset and flush clear alike
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bds_flag <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        bds_flag <= head_ctrl;
      end
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (!enq && deq) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_predecode_queue.sv
// Directed bench for inst_predecode_queue (DEPTH=8).
module tb_inst_predecode_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_fault;
  logic [31:0] in_inst, out_inst, in_pc, out_pc;
  logic        out_valid, out_ready, out_fault, out_is_bds;
  logic [3:0]  out_class;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  inst_predecode_queue #(.DEPTH(8), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_fault(in_fault),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_class(out_class), .out_fault(out_fault),
    .out_is_bds(out_is_bds), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic fault);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_fault = fault;
    tick();
    in_valid = 1'b0; in_fault = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] cls_inst [12] = '{32'h8C820004, 32'hAC820004, 32'h0000000C, 32'hFC000000,
                                 32'h00221820, 32'h00000018, 32'h40000000, 32'h00000030,
                                 32'h0000000D, 32'hBC000000, 32'h24010005, 32'h04180000};
  logic [3:0]  cls_exp  [12] = '{4'd1, 4'd2, 4'd8, 4'd15, 4'd0, 4'd5, 4'd6, 4'd7,
                                 4'd9, 4'd10, 4'd0, 4'd15};

  logic [31:0] model [$];
  logic [31:0] next_pc;
  logic        exp_enq, exp_deq;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    in_fault = 1'b0; out_ready = 1'b0;

    // T1 reset
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_inst",  out_inst,       32'd0);
    rst = 1'b0; #1;
    check("rel_in_ready",  32'(in_ready),  32'd1);

    // T2 classification, with no-bypass latency check on the first word
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_inst = cls_inst[i]; in_pc = 32'h40 + 32'(i) * 4; #1;
      if (i == 0) check("no_bypass", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      check($sformatf("cls_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("cls_code_%0d", i),  32'(out_class), 32'(cls_exp[i]));
      pop();
    end
    check("cls_count", 32'(count), 32'd0);

    // T3 branch held until delay slot is queued
    push(32'h10220003, 32'h100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("br_hold", 32'(out_valid), 32'd0);
      tick();
    end
    push(32'h00221820, 32'h104, 1'b0);
    check("br_valid", 32'(out_valid), 32'd1);
    check("br_class", 32'(out_class), 32'd3);
    check("br_not_bds", 32'(out_is_bds), 32'd0);
    pop();
    check("bds_valid", 32'(out_valid), 32'd1);
    check("bds_pc", out_pc, 32'h104);
    check("bds_flag", 32'(out_is_bds), 32'd1);
    pop();
    push(32'h00000020, 32'h108, 1'b0);
    check("bds_cleared", 32'(out_is_bds), 32'd0);
    pop();
    push(32'h0C000010, 32'h10C, 1'b0);
    check("jal_hold", 32'(out_valid), 32'd0);
    push(32'h00000020, 32'h110, 1'b0);
    check("jal_class", 32'(out_class), 32'd4);
    pop();
    check("jal_bds", 32'(out_is_bds), 32'd1);
    pop();

    // T4 full and wrap
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_inst = 32'h00000020 | (32'(i) << 11); in_pc = 32'h1000 + 32'(i) * 4; #1;
      check($sformatf("fill_ready_%0d", i), 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
      if (i < 8) model.push_back(in_pc);
      tick();
    end
    in_valid = 1'b0;
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(in_ready), 32'd0);
    next_pc = 32'h1020;
    for (int c = 0; c < 27; c++) begin
      in_valid = (c < 20); in_inst = 32'h00000020; in_pc = next_pc; out_ready = 1'b1; #1;
      exp_enq = in_valid && (model.size() != 8);
      exp_deq = (model.size() != 0);
      check("wrap_ready", 32'(in_ready), 32'(model.size() != 8));
      check("wrap_count", 32'(count), 32'(model.size()));
      check("wrap_valid", 32'(out_valid), 32'(exp_deq));
      if (exp_deq) check("wrap_order", out_pc, model[0]);
      tick();
      if (exp_deq) void'(model.pop_front());
      if (exp_enq) begin
        model.push_back(next_pc);
        next_pc += 4;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("drained", 32'(count), 32'd0);

    // T5 flush with simultaneous enqueue and dequeue
    for (int i = 0; i < 5; i++) push(32'h00000020, 32'h2000 + 32'(i) * 4, 1'b0);
    check("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00000020; in_pc = 32'h3000; out_ready = 1'b1; #1;
    check("flush_head_valid", 32'(out_valid), 32'd1);
    check("flush_head_pc", out_pc, 32'h2000);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("post_flush_count", 32'(count), 32'd0);
    check("post_flush_valid", 32'(out_valid), 32'd0);
    check("post_flush_bds", 32'(out_is_bds), 32'd0);

    // T6 faulting branch presented without waiting
    push(32'h10220003, 32'h400, 1'b1);
    check("fault_valid", 32'(out_valid), 32'd1);
    check("fault_flag", 32'(out_fault), 32'd1);
    check("fault_class", 32'(out_class), 32'd3);
    pop();
    push(32'h00000020, 32'h404, 1'b0);
    check("fault_next_bds", 32'(out_is_bds), 32'd1);
    check("fault_next_nf", 32'(out_fault), 32'd0);
    pop();

    // Reset mid-operation
    push(32'h00000020, 32'h500, 1'b0);
    push(32'h00000020, 32'h504, 1'b0);
    rst = 1'b1; #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pc", out_pc, 32'd0);
    tick();
    rst = 1'b0; #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_release", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
